// File: rtl/conv_pkg.sv
// Shared definitions for the CONV layer sequencing controller.
//   state_t     : controller states
//   CSEL_*      : layer-memory select codes
//   CONV_IMG_W  : default input / layer-0 image width (power of two)
//   CONV_ADDR_W : default address width, log2(CONV_IMG_W^2)
//   tap_offset  : 3x3 window tap index -> signed (row, col) offset
package conv_pkg;

    localparam int unsigned CONV_IMG_W  = 64;
    localparam int unsigned CONV_ADDR_W = 12;

    localparam logic [2:0] CSEL_NONE = 3'b000;
    localparam logic [2:0] CSEL_L0   = 3'b001;
    localparam logic [2:0] CSEL_L1   = 3'b011;

    typedef enum logic [2:0] {
        IDLE,
        CONV_TAP,
        CONV_WR,
        POOL_RD,
        POOL_WR,
        DONE
    } state_t;

    // Offsets are -1, 0 or +1, held as 2-bit two's complement.
    typedef struct packed {
        logic signed [1:0] dr;
        logic signed [1:0] dc;
    } tap_off_t;

    // dr = k/3 - 1, dc = k%3 - 1 for taps 0..8.
    function automatic tap_off_t tap_offset(input logic [3:0] k);
        tap_off_t o;
        case (k)
            4'd0, 4'd1, 4'd2: o.dr = -2'sd1;
            4'd3, 4'd4, 4'd5: o.dr = 2'sd0;
            default:          o.dr = 2'sd1;
        endcase
        case (k)
            4'd0, 4'd3, 4'd6: o.dc = -2'sd1;
            4'd1, 4'd4, 4'd7: o.dc = 2'sd0;
            default:          o.dc = 2'sd1;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/conv_win_addr.sv
// Combinational 3x3 window address generator.
// Maps the centre pixel (r, c) and tap index k to the input-image address of
// that tap, flagging taps that fall outside the image (zero padding).
//   r, c  in  : centre pixel row / column
//   k     in  : tap index 0..8
//   iaddr out : rr*IMG_W + cc, or 0 for a padded tap
//   pad   out : tap lies outside the image
module conv_win_addr
    import conv_pkg::*;
#(
    parameter int unsigned IMG_W  = CONV_IMG_W,
    parameter int unsigned ADDR_W = CONV_ADDR_W
) (
    input  logic [$clog2(IMG_W)-1:0] r,
    input  logic [$clog2(IMG_W)-1:0] c,
    input  logic [3:0]               k,
    output logic [ADDR_W-1:0]        iaddr,
    output logic                     pad
);

    localparam int unsigned LW = $clog2(IMG_W);

    tap_off_t    off;
    logic [LW:0] rr;
    logic [LW:0] cc;

    // Tap coordinates range over -1..IMG_W. With one extra bit both -1 (all
    // ones) and IMG_W (1 << LW) set the top bit, while 0..IMG_W-1 never do,
    // so the top bit alone is the out-of-image test.
    always_comb begin
        off   = tap_offset(k);
        rr    = {1'b0, r} + {{(LW-1){off.dr[1]}}, off.dr};
        cc    = {1'b0, c} + {{(LW-1){off.dc[1]}}, off.dc};
        pad   = rr[LW] | cc[LW];
        iaddr = pad ? '0 : ADDR_W'({rr[LW-1:0], cc[LW-1:0]});
    end

endmodule

// File: rtl/conv_sched_ctrl.sv
// Sequencing controller for the CONV layer engine.
// Runs the ready/busy handshake, scans the image with a zero-padded 3x3
// window (layer 0: conv + ReLU), then 2x2 max-pools layer 0 into layer 1,
// steering the shared MAC / max datapath through per-cycle strobes.
//   clk, reset (async, active low), ready   : clock, reset, host start
//   busy                                    : run in progress
//   iaddr                                   : input image address
//   cwr, caddr_wr / crd, caddr_rd, csel     : layer-memory write / read
//   mac_clr, mac_en, k_idx, pad             : accumulator control
//   pool_clr, pool_en                       : max register control
//   dp_sel                                  : write data source (0 conv, 1 pool)
// All outputs are registered: the values presented during a cycle belong to
// the state entered at the start of that cycle.
module conv_sched_ctrl
    import conv_pkg::*;
#(
    parameter int unsigned IMG_W  = CONV_IMG_W,
    parameter int unsigned ADDR_W = CONV_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ready,
    output logic              busy,
    output logic [ADDR_W-1:0] iaddr,
    output logic              cwr,
    output logic [ADDR_W-1:0] caddr_wr,
    output logic              crd,
    output logic [ADDR_W-1:0] caddr_rd,
    output logic [2:0]        csel,
    output logic              mac_clr,
    output logic              mac_en,
    output logic [3:0]        k_idx,
    output logic              pad,
    output logic              pool_clr,
    output logic              pool_en,
    output logic              dp_sel
);

    localparam int unsigned LW = $clog2(IMG_W);

    // Current position: (r, c, k) for layer 0, (pr, pc, j) for layer 1.
    state_t        state, n_state;
    logic [LW-1:0] r, c, n_r, n_c;
    logic [3:0]    k, n_k;
    logic [LW-2:0] pr, pc, n_pr, n_pc;
    logic [1:0]    j, n_j;

    logic [ADDR_W-1:0] win_iaddr;
    logic              win_pad;

    logic              busy_d, cwr_d, crd_d, mac_clr_d, mac_en_d;
    logic              pad_d, pool_clr_d, pool_en_d, dp_sel_d;
    logic [ADDR_W-1:0] iaddr_d, caddr_wr_d, caddr_rd_d;
    logic [2:0]        csel_d;
    logic [3:0]        k_idx_d;

    // Next state and position.
    always_comb begin
        n_state = state;
        n_r     = r;
        n_c     = c;
        n_k     = k;
        n_pr    = pr;
        n_pc    = pc;
        n_j     = j;
        unique case (state)
            IDLE: begin
                if (ready) begin
                    n_state = CONV_TAP;
                    n_r     = '0;
                    n_c     = '0;
                    n_k     = '0;
                end
            end
            CONV_TAP: begin
                if (k == 4'd8) n_state = CONV_WR;
                else           n_k     = k + 4'd1;
            end
            CONV_WR: begin
                n_k = '0;
                n_c = c + 1'b1;
                if (c == '1) n_r = r + 1'b1;
                if (c == '1 && r == '1) begin
                    n_state = POOL_RD;
                    n_pr    = '0;
                    n_pc    = '0;
                    n_j     = '0;
                end else begin
                    n_state = CONV_TAP;
                end
            end
            POOL_RD: begin
                if (j == 2'd3) n_state = POOL_WR;
                else           n_j     = j + 2'd1;
            end
            POOL_WR: begin
                n_j  = '0;
                n_pc = pc + 1'b1;
                if (pc == '1) n_pr = pr + 1'b1;
                n_state = (pc == '1 && pr == '1) ? DONE : POOL_RD;
            end
            DONE:    n_state = IDLE;
            default: n_state = IDLE;
        endcase
    end

    // Window address for the tap about to be presented.
    conv_win_addr #(
        .IMG_W  (IMG_W),
        .ADDR_W (ADDR_W)
    ) u_win_addr (
        .r     (n_r),
        .c     (n_c),
        .k     (n_k),
        .iaddr (win_iaddr),
        .pad   (win_pad)
    );

    // Output values for the state being entered.
    always_comb begin
        busy_d     = (n_state != IDLE);
        iaddr_d    = '0;
        cwr_d      = 1'b0;
        caddr_wr_d = '0;
        crd_d      = 1'b0;
        caddr_rd_d = '0;
        csel_d     = CSEL_NONE;
        mac_clr_d  = 1'b0;
        mac_en_d   = 1'b0;
        k_idx_d    = '0;
        pad_d      = 1'b0;
        pool_clr_d = 1'b0;
        pool_en_d  = 1'b0;
        dp_sel_d   = 1'b0;
        unique case (n_state)
            CONV_TAP: begin
                mac_en_d  = 1'b1;
                mac_clr_d = (n_k == 4'd0);
                k_idx_d   = n_k;
                pad_d     = win_pad;
                iaddr_d   = win_iaddr;
            end
            CONV_WR: begin
                cwr_d      = 1'b1;
                csel_d     = CSEL_L0;
                caddr_wr_d = ADDR_W'({n_r, n_c});
            end
            POOL_RD: begin
                crd_d      = 1'b1;
                csel_d     = CSEL_L0;
                // (2pr + j/2)*IMG_W + 2pc + j%2 as a bit concatenation
                caddr_rd_d = ADDR_W'({n_pr, n_j[1], n_pc, n_j[0]});
                pool_clr_d = (n_j == 2'd0);
                pool_en_d  = (n_j != 2'd0);
            end
            POOL_WR: begin
                cwr_d      = 1'b1;
                csel_d     = CSEL_L1;
                caddr_wr_d = ADDR_W'({n_pr, n_pc});
                dp_sel_d   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            r        <= '0;
            c        <= '0;
            k        <= '0;
            pr       <= '0;
            pc       <= '0;
            j        <= '0;
            busy     <= 1'b0;
            iaddr    <= '0;
            cwr      <= 1'b0;
            caddr_wr <= '0;
            crd      <= 1'b0;
            caddr_rd <= '0;
            csel     <= CSEL_NONE;
            mac_clr  <= 1'b0;
            mac_en   <= 1'b0;
            k_idx    <= '0;
            pad      <= 1'b0;
            pool_clr <= 1'b0;
            pool_en  <= 1'b0;
            dp_sel   <= 1'b0;
        end else begin
            state    <= n_state;
            r        <= n_r;
            c        <= n_c;
            k        <= n_k;
            pr       <= n_pr;
            pc       <= n_pc;
            j        <= n_j;
            busy     <= busy_d;
            iaddr    <= iaddr_d;
            cwr      <= cwr_d;
            caddr_wr <= caddr_wr_d;
            crd      <= crd_d;
            caddr_rd <= caddr_rd_d;
            csel     <= csel_d;
            mac_clr  <= mac_clr_d;
            mac_en   <= mac_en_d;
            k_idx    <= k_idx_d;
            pad      <= pad_d;
            pool_clr <= pool_clr_d;
            pool_en  <= pool_en_d;
            dp_sel   <= dp_sel_d;
        end
    end

endmodule

// File: tb/tb_conv_sched_ctrl.sv
// Testbench for conv_sched_ctrl: expected outputs are derived from the cycle
// offset within a run (t = 0 at the first busy cycle) by plain arithmetic.
module tb_conv_sched_ctrl;

    localparam int unsigned W       = 64;
    localparam int unsigned L0_CYC  = 10 * W * W;
    localparam int unsigned L1_CYC  = 5 * (W / 2) * (W / 2);
    localparam int unsigned RUN_CYC = L0_CYC + L1_CYC + 1;

    typedef struct packed {
        logic        busy;
        logic [11:0] iaddr;
        logic        cwr;
        logic [11:0] caddr_wr;
        logic        crd;
        logic [11:0] caddr_rd;
        logic [2:0]  csel;
        logic        mac_clr;
        logic        mac_en;
        logic [3:0]  k_idx;
        logic        pad;
        logic        pool_clr;
        logic        pool_en;
        logic        dp_sel;
    } out_t;

    logic        clk;
    logic        reset;
    logic        ready;
    logic        busy;
    logic [11:0] iaddr;
    logic        cwr;
    logic [11:0] caddr_wr;
    logic        crd;
    logic [11:0] caddr_rd;
    logic [2:0]  csel;
    logic        mac_clr;
    logic        mac_en;
    logic [3:0]  k_idx;
    logic        pad;
    logic        pool_clr;
    logic        pool_en;
    logic        dp_sel;

    out_t dut_o;
    assign dut_o = {busy, iaddr, cwr, caddr_wr, crd, caddr_rd, csel,
                    mac_clr, mac_en, k_idx, pad, pool_clr, pool_en, dp_sel};

    conv_sched_ctrl #(
        .IMG_W  (64),
        .ADDR_W (12)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ready    (ready),
        .busy     (busy),
        .iaddr    (iaddr),
        .cwr      (cwr),
        .caddr_wr (caddr_wr),
        .crd      (crd),
        .caddr_rd (caddr_rd),
        .csel     (csel),
        .mac_clr  (mac_clr),
        .mac_en   (mac_en),
        .k_idx    (k_idx),
        .pad      (pad),
        .pool_clr (pool_clr),
        .pool_en  (pool_en),
        .dp_sel   (dp_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: run activity and cycle offset within the run.
    bit          m_act;
    int unsigned m_t;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_act <= 1'b0;
            m_t   <= 0;
        end else if (m_act) begin
            if (m_t == RUN_CYC - 1) m_act <= 1'b0;
            else                    m_t   <= m_t + 1;
        end else if (ready) begin
            m_act <= 1'b1;
            m_t   <= 0;
        end
    end

    function automatic out_t model_out(input bit act, input int unsigned t);
        out_t o;
        o = '0;
        if (act) begin
            o.busy = 1'b1;
            if (t < L0_CYC) begin
                int unsigned pix, ph, r, c;
                int rr, cc;
                pix = t / 10;
                ph  = t % 10;
                r   = pix / W;
                c   = pix % W;
                if (ph < 9) begin
                    rr        = int'(r) + int'(ph / 3) - 1;
                    cc        = int'(c) + int'(ph % 3) - 1;
                    o.mac_en  = 1'b1;
                    o.mac_clr = (ph == 0);
                    o.k_idx   = 4'(ph);
                    if (rr < 0 || rr >= int'(W) || cc < 0 || cc >= int'(W)) o.pad = 1'b1;
                    else o.iaddr = 12'(rr * int'(W) + cc);
                end else begin
                    o.cwr      = 1'b1;
                    o.csel     = 3'b001;
                    o.caddr_wr = 12'(r * W + c);
                end
            end else if (t < L0_CYC + L1_CYC) begin
                int unsigned u, p, ph, pr, pc;
                u  = t - L0_CYC;
                p  = u / 5;
                ph = u % 5;
                pr = p / (W / 2);
                pc = p % (W / 2);
                if (ph < 4) begin
                    o.crd      = 1'b1;
                    o.csel     = 3'b001;
                    o.caddr_rd = 12'((2 * pr + ph / 2) * W + 2 * pc + ph % 2);
                    o.pool_clr = (ph == 0);
                    o.pool_en  = (ph != 0);
                end else begin
                    o.cwr      = 1'b1;
                    o.csel     = 3'b011;
                    o.caddr_wr = 12'(pr * (W / 2) + pc);
                    o.dp_sel   = 1'b1;
                end
            end
        end
        return o;
    endfunction

    // Hand-derived spot values at corners of the image.
    bit          pad00_tab[9]   = '{1, 1, 1, 1, 0, 0, 1, 0, 0};
    int unsigned iaddr00_tab[9] = '{0, 0, 0, 0, 0, 1, 0, 64, 65};
    int unsigned pool_tab[4]    = '{4030, 4031, 4094, 4095};

    task automatic spot(input int unsigned t);
        if (t < 9) begin
            check("p00_pad", pad, pad00_tab[t]);
            check("p00_iaddr", iaddr, iaddr00_tab[t]);
        end
        if (t == 9) check("p00_wr", {cwr, csel, caddr_wr}, {1'b1, 3'b001, 12'd0});
        if (t == 40950) check("p63_k0", {pad, iaddr}, {1'b0, 12'd4030});
        if (t == 40954) check("p63_k4", {pad, iaddr}, {1'b0, 12'd4095});
        if (t == 40952 || (t >= 40955 && t <= 40958)) check("p63_pad", pad, 1);
        if (t == 40959) check("p63_wr", {cwr, csel, caddr_wr}, {1'b1, 3'b001, 12'd4095});
        if (t >= 46075 && t <= 46078) begin
            check("pool_rd", {crd, caddr_rd}, {1'b1, 12'(pool_tab[t - 46075])});
            check("pool_clr", pool_clr, (t == 46075));
        end
        if (t == 46079)
            check("pool_wr", {cwr, csel, caddr_wr, dp_sel}, {1'b1, 3'b011, 12'd1023, 1'b1});
    endtask

    int unsigned trace_err = 0;
    int unsigned excl_err  = 0;
    int unsigned busy_len  = 0;
    int unsigned cnt_l0    = 0;
    int unsigned cnt_l1    = 0;
    int unsigned cnt_rd    = 0;
    int unsigned runs_done = 0;
    bit          prev_busy = 1'b0;

    always @(negedge clk) begin
        out_t e;
        e = model_out(m_act, m_t);
        if (dut_o !== e) begin
            if (trace_err == 0)
                $display("[TB] first trace difference at t=%0d act=%0d got 0x%0h exp 0x%0h",
                         m_t, m_act, dut_o, e);
            trace_err++;
        end
        if ((cwr && crd) || (!cwr && !crd && csel != 3'b000)) excl_err++;
        if (!reset) begin
            busy_len  = 0;
            cnt_l0    = 0;
            cnt_l1    = 0;
            cnt_rd    = 0;
            prev_busy = 1'b0;
        end else begin
            if (busy) begin
                busy_len++;
                if (cwr && csel == 3'b001) cnt_l0++;
                if (cwr && csel == 3'b011) cnt_l1++;
                if (crd) cnt_rd++;
            end
            if (!busy && prev_busy) begin
                check("busy_len", busy_len, RUN_CYC);
                check("cnt_l0_wr", cnt_l0, W * W);
                check("cnt_l1_wr", cnt_l1, (W / 2) * (W / 2));
                check("cnt_rd", cnt_rd, W * W);
                runs_done++;
                busy_len = 0;
                cnt_l0   = 0;
                cnt_l1   = 0;
                cnt_rd   = 0;
            end
            prev_busy = busy;
            if (m_act) spot(m_t);
        end
    end

    task automatic wait_busy(input logic level, input int unsigned limit, input string tag);
        int unsigned n = 0;
        while (busy !== level && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(tag, busy, level);
    endtask

    initial begin
        int unsigned gap;
        reset = 1'b0;
        ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out", dut_o, '0);
        reset = 1'b1;
        repeat ($urandom_range(2, 8)) @(negedge clk);
        check("idle_busy", busy, 0);

        // Run 1: single-cycle start pulse, random ready during busy, abort.
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        wait_busy(1'b1, 5, "start1");
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            ready = 1'($urandom_range(0, 1));
        end
        #2 reset = 1'b0;
        #1 check("async_rst", dut_o, '0);
        ready = 1'b1;
        repeat ($urandom_range(2, 6)) @(negedge clk);
        reset = 1'b1;

        // Run 2: restart from (0,0), random ready, then held high to the end.
        wait_busy(1'b1, 5, "start2");
        for (int i = 0; i < 46000; i++) begin
            @(negedge clk);
            ready = 1'($urandom_range(0, 1));
        end
        ready = 1'b1;
        wait_busy(1'b0, 200, "end2");
        gap = 0;
        while (!busy && gap < 10) begin
            @(negedge clk);
            gap++;
        end
        check("restart_gap", gap, 1);
        repeat (12) @(negedge clk);
        ready = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        check("trace", trace_err, 0);
        check("exclusive", excl_err, 0);
        check("runs_done", runs_done, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_sched_ctrl.md
# conv_sched_ctrl

Sequencing controller for the CONV layer engine. Runs the host ready/busy handshake, scans the 64×64 input image with a zero-padded 3×3 window, and drives the shared MAC/ReLU/max-pool datapath through per-cycle strobes. Also issues all layer-memory read and write commands: layer 0 holds conv+ReLU results, layer 1 holds 2×2 max-pool results. Sits between the top-level CONV wrapper ports and the arithmetic datapath; holds no pixel data itself.

## Interface
- IMG_W, default 64: input and L0 image width/height (power of two).
- ADDR_W, default 12: width of iaddr, caddr_wr and caddr_rd (log2(IMG_W²)).
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ready  in  1  host start request.
- busy  out  1  run in progress.
- iaddr  out  ADDR_W  input image address.
- cwr  out  1  layer-memory write strobe.
- caddr_wr  out  ADDR_W  layer-memory write address.
- crd  out  1  layer-memory read strobe.
- caddr_rd  out  ADDR_W  layer-memory read address.
- csel  out  3  layer select: 000 none, 001 L0, 011 L1.
- mac_clr  out  1  load accumulator with the current product (discard old sum).
- mac_en  out  1  accumulate idata×kernel[k_idx] (zero if pad).
- k_idx  out  4  kernel tap index, 0–8.
- pad  out  1  current tap is outside the image; datapath uses operand 0.
- pool_clr  out  1  load the max register with cdata_rd.
- pool_en  out  1  max register := max(reg, cdata_rd).
- dp_sel  out  1  cdata_wr source: 0 = bias+ReLU result, 1 = max register.

## Operation
- States: IDLE, CONV_TAP, CONV_WR, POOL_RD, POOL_WR, DONE.
- IDLE: busy=0; all strobes 0; csel=000. When ready=1 is sampled, go to CONV_TAP with r=c=k=0.
- CONV_TAP, k=0..8, one cycle each:
  - Offsets: dr = k/3 − 1, dc = k%3 − 1.
  - Tap coordinates: rr = r+dr, cc = c+dc.
  - mac_en=1; mac_clr=1 only when k=0; k_idx=k.
  - If rr or cc is outside 0..IMG_W−1: pad=1 and iaddr=0.
  - Otherwise: pad=0 and iaddr = rr·IMG_W + cc.
  - After k=8, go to CONV_WR.
- CONV_WR, one cycle: cwr=1, csel=001, caddr_wr = r·IMG_W + c, dp_sel=0.
  - Then advance c (row-major); c wraps to 0 and increments r.
  - After (IMG_W−1, IMG_W−1), go to POOL_RD with pr=pc=j=0. Otherwise return to CONV_TAP with k=0.
- POOL_RD, j=0..3, one cycle each:
  - crd=1, csel=001.
  - caddr_rd = (2pr + j/2)·IMG_W + 2pc + j%2.
  - pool_clr=1 when j=0; pool_en=1 when j=1..3.
- POOL_WR, one cycle: cwr=1, csel=011, caddr_wr = pr·(IMG_W/2) + pc, dp_sel=1.
  - Advance pc/pr the same way as c/r.
  - After (IMG_W/2−1, IMG_W/2−1), go to DONE.
- DONE, one cycle: busy=1, no strobes. Then go to IDLE.
- Exclusivity: cwr and crd are never high together. csel=000 whenever neither strobe is high. Address outputs are 0 when their strobe is low.
- ready while busy=1 is ignored. ready held high through DONE starts a new run from IDLE on the next sampled edge.
- reset low at any time: immediately clears all state and outputs to 0 (state IDLE) and aborts the run. No partial-run resume.

## Timing
- All outputs are registered and zero during reset.
- Cycle n: ready sampled high in IDLE. Cycle n+1: busy=1 and the first CONV_TAP is presented.
- The datapath samples idata/cdata_rd with the strobe and address in the same cycle. The accumulator holds the full sum at the start of CONV_WR; the max register is final at the start of POOL_WR.
- Layer 0 takes 10 cycles/pixel × IMG_W² = 40960 cycles. Layer 1 takes 5 cycles/pixel × (IMG_W/2)² = 5120 cycles.
- busy high for exactly 46081 cycles, DONE included.

## Structure
- Shared package conv_pkg:
  - state enum;
  - csel codes CSEL_NONE, CSEL_L0, CSEL_L1;
  - IMG_W / ADDR_W constants;
  - tap-offset function.
- One sub-module, conv_win_addr: combinational (r, c, k) → (iaddr, pad). Instantiated once; FSM, counters and pool addressing stay in the top.

## Test plan
- Pixel (0,0): k=0..8 give pad 1,1,1,1,0,0,1,0,0 and iaddr 0,0,0,0,0,1,0,64,65. Then cwr=1, csel=001, caddr_wr=0.
- Pixel (63,63): k=0 gives iaddr 4030, pad=0. k=4 gives iaddr 4095. k=2,5,6,7,8 give pad=1. CONV_WR gives caddr_wr=4095.
- Pool (31,31): caddr_rd 4030, 4031, 4094, 4095 with pool_clr on the first only. Then cwr, csel=011, caddr_wr=1023, dp_sel=1.
- Full run: busy high 46081 cycles. 4096 cwr pulses with csel=001, 1024 with csel=011, 4096 crd pulses. cwr and crd never overlap.
- Reset low 500 cycles into a run: all outputs are 0 asynchronously. After release with ready=1, the run restarts at pixel (0,0) and completes normally.
- ready toggled during busy: no effect. ready held high: a second run starts one cycle after busy falls.
